// File: rtl/pmux_ift.sv
// pmux_ift: taint-tracking parallel multiplexer with registered outputs.
// A one-hot select S chooses one B slice (lowest set bit wins) or A when no
// bit is set. The output taint is the selected candidate's taint, plus the
// select taint S_t whenever the select vector could influence the result.
// Build option: define PMUX_IFT_PRECISE_EN to block S_t when all candidate
// words are equal. Without the macro, S_t is always propagated.
module pmux_ift #(
    parameter int WIDTH   = 2,
    parameter int S_WIDTH = 1,
    parameter int TAINT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           A,
    input  logic [TAINT_W-1:0]         A_t,
    input  logic [WIDTH*S_WIDTH-1:0]   B,
    input  logic [TAINT_W*S_WIDTH-1:0] B_t,
    input  logic [S_WIDTH-1:0]         S,
    input  logic [TAINT_W-1:0]         S_t,
    output logic [WIDTH-1:0]           Y,
    output logic [TAINT_W-1:0]         Y_t
);

    logic [WIDTH-1:0]   sel;
    logic [TAINT_W-1:0] sel_t;
    logic               found;
    logic               infl;
    logic [WIDTH-1:0]   y_d, y_q;
    logic [TAINT_W-1:0] y_t_d, y_t_q;

    // Priority select: the lowest set S bit picks its B slice; A otherwise.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' with every output given a
        // default first, so later statements see earlier results and no latch forms.
        sel   = A;
        sel_t = A_t;
        found = 1'b0;
        for (int i = 0; i < S_WIDTH; i++) begin
            if (S[i] && !found) begin
                sel   = B[i*WIDTH +: WIDTH];
                sel_t = B_t[i*TAINT_W +: TAINT_W];
                found = 1'b1;
            end
        end
    end

`ifdef PMUX_IFT_PRECISE_EN
    // Precise influence: S matters only if some candidate differs from the pick.
    always_comb begin
        infl = (A != sel);
        for (int i = 0; i < S_WIDTH; i++) begin
            if (B[i*WIDTH +: WIDTH] != sel) begin
                infl = 1'b1;
            end
        end
    end
`else
    // Conservative influence: the select taint always reaches the output.
    always_comb begin
        infl = 1'b1;
    end
`endif

    // Next-state: selected word, and its taint joined with the gated select taint.
    always_comb begin
        y_d   = sel;
        y_t_d = sel_t | (infl ? S_t : '0);
    end

    // Output registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking '<=' so every flop samples
        // values from before the edge, independent of statement order.
        if (!rst_n) begin
            y_q   <= '0;
            y_t_q <= '0;
        end else begin
            y_q   <= y_d;
            y_t_q <= y_t_d;
        end
    end

    assign Y   = y_q;
    assign Y_t = y_t_q;

endmodule

// File: tb/tb_pmux_ift.sv
// Self-checking bench for pmux_ift: directed vectors, a randomized sweep,
// reset behaviour and a two-select instance, against a behavioural model.
module tb_pmux_ift;

    typedef struct packed {
        logic [1:0]  y;
        logic [31:0] yt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  a;
    logic [31:0] a_t;
    logic [1:0]  b;
    logic [31:0] b_t;
    logic [0:0]  s;
    logic [31:0] s_t;
    logic [1:0]  y;
    logic [31:0] y_t;

    logic [3:0]  b2;
    logic [63:0] b2_t;
    logic [1:0]  s2;
    logic [1:0]  y2;
    logic [31:0] y2_t;

    int checks   = 0;
    int failures = 0;

    pmux_ift #(.WIDTH(2), .S_WIDTH(1), .TAINT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .A(a), .A_t(a_t), .B(b), .B_t(b_t), .S(s), .S_t(s_t),
        .Y(y), .Y_t(y_t)
    );

    pmux_ift #(.WIDTH(2), .S_WIDTH(2), .TAINT_W(32)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .A(a), .A_t(a_t), .B(b2), .B_t(b2_t), .S(s2), .S_t(s_t),
        .Y(y2), .Y_t(y2_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: candidates as a list; influence iff the list is not all equal.
    function automatic exp_t ref_model(input int n, input logic [1:0] av,
                                       input logic [31:0] atv, input logic [3:0] bv,
                                       input logic [63:0] btv, input logic [1:0] sv,
                                       input logic [31:0] stv);
        logic [1:0] cands[$];
        int         k;
        logic       infl;
        exp_t       e;
        cands.push_back(av);
        for (int i = 0; i < n; i++) cands.push_back(bv[i*2 +: 2]);
        k = -1;
        for (int i = n - 1; i >= 0; i--) if (sv[i]) k = i;
        if (k < 0) begin
            e.y  = av;
            e.yt = atv;
        end else begin
            e.y  = bv[k*2 +: 2];
            e.yt = btv[k*32 +: 32];
        end
        infl = 1'b0;
        foreach (cands[i]) if (cands[i] != cands[0]) infl = 1'b1;
`ifndef PMUX_IFT_PRECISE_EN
        infl = 1'b1;
`endif
        e.yt = e.yt | (infl ? stv : 32'h0);
        return e;
    endfunction

    function automatic exp_t model1();
        return ref_model(1, a, a_t, {2'b00, b}, {32'h0, b_t}, {1'b0, s}, s_t);
    endfunction

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b1;
        a = $urandom; a_t = $urandom; b = $urandom; b_t = $urandom;
        s = $urandom; s_t = $urandom;
        b2 = $urandom; b2_t = {$urandom, $urandom}; s2 = $urandom;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (y !== 2'b00 || y_t !== 32'h0) begin
            failures++;
            $display("FAIL reset_async: Y=%b Y_t=%h required Y=00 Y_t=00000000", y, y_t);
        end
        @(posedge clk); #1;
        checks++;
        if (y !== 2'b00 || y_t !== 32'h0 || y2 !== 2'b00 || y2_t !== 32'h0) begin
            failures++;
            $display("FAIL reset_hold: Y=%b Y_t=%h Y2=%b Y2_t=%h required all zero", y, y_t, y2, y2_t);
        end
        #2 rst_n = 1'b1;
        a = 2'b01; s = 1'b0; a_t = 32'h1; b = 2'b10; b_t = 32'h0; s_t = 32'h0;
        e = model1();
        @(posedge clk); #1;
        checks++;
        if (y !== 2'b01 || y_t !== 32'h1 || e.y !== 2'b01) begin
            failures++;
            $display("FAIL reset_first_capture: Y=%b Y_t=%h required Y=01 Y_t=00000001", y, y_t);
        end
    endtask

    task automatic test_directed();
        logic [31:0] mask_exp;
`ifdef PMUX_IFT_PRECISE_EN
        mask_exp = 32'h2;
`else
        mask_exp = 32'h6;
`endif
        a = 2'b00; b = 2'b11; s = 1'b1; a_t = 32'h1; b_t = 32'h2; s_t = 32'h4;
        @(posedge clk); #1;
        checks++;
        if (y !== 2'b11 || y_t !== 32'h6) begin
            failures++;
            $display("FAIL select_b: Y=%b Y_t=%h required Y=11 Y_t=00000006", y, y_t);
        end
        a = 2'b11; b = 2'b10; s = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (y !== 2'b11 || y_t !== 32'h5) begin
            failures++;
            $display("FAIL select_a: Y=%b Y_t=%h required Y=11 Y_t=00000005", y, y_t);
        end
        a = 2'b00; b = 2'b00; s = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (y !== 2'b00 || y_t !== mask_exp) begin
            failures++;
            $display("FAIL precise_mask: Y=%b Y_t=%h required Y=00 Y_t=%h", y, y_t, mask_exp);
        end
    endtask

    task automatic test_sweep();
        logic [1:0]  a_vals[4] = '{2'b00, 2'b01, 2'b11, 2'b10};
        logic [1:0]  b_vals[3] = '{2'b00, 2'b10, 2'b11};
        logic [31:0] pat[8][3];
        exp_t        e, prev;
        bit          have_prev;
        for (int p = 0; p < 8; p++)
            for (int j = 0; j < 3; j++) pat[p][j] = $urandom | (32'h1 << (p * 3 + j));
        have_prev = 1'b0;
        prev = '0;
        for (int ai = 0; ai < 4; ai++)
            for (int si = 1; si >= 0; si--)
                for (int p = 0; p < 8; p++)
                    for (int bi = 0; bi < 3; bi++) begin
                        a = a_vals[ai]; s = si[0]; b = b_vals[bi];
                        a_t = pat[p][0]; b_t = pat[p][1]; s_t = pat[p][2];
                        e = model1();
                        if (have_prev) begin
                            checks++;
                            if (y !== prev.y || y_t !== prev.yt) begin
                                failures++;
                                $display("FAIL sweep_latency: Y=%b Y_t=%h required Y=%b Y_t=%h before edge",
                                         y, y_t, prev.y, prev.yt);
                            end
                        end
                        @(posedge clk); #1;
                        checks++;
                        if (y !== e.y || y_t !== e.yt) begin
                            failures++;
                            $display("FAIL sweep A=%b B=%b S=%b: Y=%b Y_t=%h required Y=%b Y_t=%h",
                                     a, b, s, y, y_t, e.y, e.yt);
                        end
                        prev = e;
                        have_prev = 1'b1;
                    end
    endtask

    task automatic test_glitch();
        exp_t e;
        a = 2'b01; b = 2'b10; s = 1'b1; a_t = 32'hAAAA; b_t = 32'h5555; s_t = 32'hF0000;
        #2 s = 1'b0; b = 2'b01;
        #2 s = 1'b1; b = 2'b11; b_t = 32'h00C0;
        e = model1();
        @(posedge clk); #1;
        checks++;
        if (y !== e.y || y_t !== e.yt) begin
            failures++;
            $display("FAIL glitch: Y=%b Y_t=%h required Y=%b Y_t=%h", y, y_t, e.y, e.yt);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        a = 2'b11; s = 1'b0; a_t = 32'hFFFF; s_t = 32'h0; b = 2'b11;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (y !== 2'b00 || y_t !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_async: Y=%b Y_t=%h required zero", y, y_t);
        end
        a = 2'b10; a_t = 32'h1234;
        @(posedge clk); #1;
        checks++;
        if (y !== 2'b00 || y_t !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_lost: Y=%b Y_t=%h required zero", y, y_t);
        end
        #2 rst_n = 1'b1;
        a = 2'b01; a_t = 32'h8; b = 2'b10; b_t = 32'h10; s = 1'b1; s_t = 32'h100;
        e = model1();
        @(posedge clk); #1;
        checks++;
        if (y !== e.y || y_t !== e.yt) begin
            failures++;
            $display("FAIL reset_mid_release: Y=%b Y_t=%h required Y=%b Y_t=%h", y, y_t, e.y, e.yt);
        end
    endtask

    task automatic test_two_select();
        exp_t e;
        a = 2'b00; a_t = 32'h1; s_t = 32'h4;
        b2 = 4'b10_01; b2_t = {32'h20, 32'h10}; s2 = 2'b11;
        @(posedge clk); #1;
        checks++;
        if (y2 !== 2'b01 || y2_t !== 32'h14) begin
            failures++;
            $display("FAIL multi_hot: Y=%b Y_t=%h required Y=01 Y_t=00000014", y2, y2_t);
        end
        for (int n = 0; n < 40; n++) begin
            a = $urandom; a_t = $urandom; s_t = $urandom;
            b2 = $urandom; b2_t = {$urandom, $urandom}; s2 = $urandom;
            if (n % 5 == 0) b2 = {a, a};
            e = ref_model(2, a, a_t, b2, b2_t, s2, s_t);
            @(posedge clk); #1;
            checks++;
            if (y2 !== e.y || y2_t !== e.yt) begin
                failures++;
                $display("FAIL two_select A=%b B=%b S=%b: Y=%b Y_t=%h required Y=%b Y_t=%h",
                         a, b2, s2, y2, y2_t, e.y, e.yt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_sweep();
        test_glitch();
        test_reset_mid();
        test_two_select();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pmux_ift.md
# pmux_ift

Taint-tracking parallel multiplexer for the information-flow-tracking (IFT) cell library. It selects one of several data words by a one-hot select vector and computes a taint vector for the result from the data taints and the select taint. Each taint bit is an independent label. The result and its taint are registered. It is instantiated by the IFT netlist generator wherever a `$pmux` cell appears.

## Interface
Parameters:
- WIDTH, 2, data word width
- S_WIDTH, 1, number of select bits / B-side candidates
- TAINT_W, 32, taint label vector width, one per data signal

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- A  input  WIDTH  default word, chosen when no S bit is set
- A_t  input  TAINT_W  taint of A
- B  input  WIDTH*S_WIDTH  candidate words; slice i is B[i*WIDTH +: WIDTH]
- B_t  input  TAINT_W*S_WIDTH  taint of each B slice, same slicing by TAINT_W
- S  input  S_WIDTH  select vector, one-hot expected
- S_t  input  TAINT_W  taint of the whole select vector
- Y  output  WIDTH  registered selected word
- Y_t  output  TAINT_W  registered taint of Y

## Operation
- Selection: k = lowest index with S[k]=1. If k exists, sel = B slice k and sel_t = B_t slice k. Otherwise sel = A and sel_t = A_t.
- Multiple S bits set: lowest index wins. This is deterministic and is not an error.
- Select-taint influence flag `infl`, precise mode: infl=1 iff at least one candidate word (A or any B slice) differs from sel. The flag answers whether a change of S could change Y.
- Output taint: Y_t_next = sel_t | (infl ? S_t : 0).
- Data taint is never masked. Only the selected candidate's taint passes; unselected candidates' taints are dropped.
- Pure combinational next-state; no internal state beyond the output registers.

## Timing
- Y and Y_t are registered on the rising clk edge. Latency is 1 cycle from input change to output.
- The register updates every cycle; there is no enable or handshake.
- rst_n low forces Y=0 and Y_t=0 immediately, independent of clk.
- Reset released: first capture occurs at the first rising edge with rst_n high.
- Reset asserted mid-stream: outputs clear at once, and the inputs applied during reset are lost.
- Inputs changing several times within one cycle: only values present at the edge matter.

## Configuration
- Macro PMUX_IFT_PRECISE_EN.
- Defined: precise select-taint rule as in Operation; S_t is blocked when all candidates are equal.
- Undefined: conservative rule with infl fixed to 1, so Y_t_next = sel_t | S_t always.
- Data path Y is identical in both builds.

## Test plan
Defaults used: WIDTH=2, S_WIDTH=1, TAINT_W=32, PMUX_IFT_PRECISE_EN defined.

- Reset: rst_n=0 with any inputs → Y=0, Y_t=0 immediately. Release, apply A=01, S=0, A_t=1 → after one edge Y=01, Y_t=0x00000001.
- Select B: A=00, B=11, S=1, A_t=0x1, B_t=0x2, S_t=0x4 → Y=11, Y_t=0x00000006.
- Select A: A=11, B=10, S=0, A_t=0x1, B_t=0x2, S_t=0x4 → Y=11, Y_t=0x00000005.
- Precise masking: A=00, B=00, S=1, A_t=0x1, B_t=0x2, S_t=0x4 → Y=00, Y_t=0x00000002. Rebuilt without the macro → Y_t=0x00000006.
- Sweep: for each A in {00,01,11,10}, S in {1,0}, B stepping 00→10→11 with a clock edge between steps, and 8 distinct {A_t,B_t,S_t} patterns → each cycle Y equals S?B:A and Y_t matches the formula, one cycle after the inputs.
- S_WIDTH=2, S=11, B={10,01} (slice0=01) → Y=01; taint from slice 0.
